breakout_block_column: RTL and testbench

Parametrised brick column for the breakout playfield, replacing the fixed per-column modules. Holds NUM_ROWS blocks, each with a multi-hit hit-point counter. Evaluates ball contact once per frame tick and emits one-cycle bounce-direction pulses to the ball controller. Drives the column pixel-on signal to the VGA mixer and keeps a saturating per-column score.

---
 rtl/breakout_block_column.sv | 163 ++++++++++++++++
 tb/tb_breakout_block_column.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/breakout_block_column.sv
// Parametrised breakout brick column: per-row hit points, per-frame contact check, bounce pulses, score.
// Optional `define BREAKOUT_HP_SHADE_EN adds pix_hp, the hit points of the block under the pixel.
module breakout_block_column #(
  parameter int NUM_ROWS        = 8,
  parameter int COL_X_L         = 574,
  parameter int BLOCK_W         = 106,
  parameter int ROW_Y0          = 4,
  parameter int BLOCK_H         = 16,
  parameter int ROW_PITCH       = 23,
  parameter int EDGE_T          = 3,
  parameter int HIT_POINTS      = 1,
  parameter int PTS_PER_BLOCK   = 1,
  parameter int SCORE_W         = 8,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [10:0]        pix_x,
  input  logic [10:0]        pix_y,
  input  logic [10:0]        ball_x_l,
  input  logic [10:0]        ball_x_r,
  input  logic [10:0]        ball_y_t,
  input  logic [10:0]        ball_y_b,
  output logic               col_on,
  output logic               move_u,
  output logic               move_d,
  output logic               move_l,
  output logic               move_r,
  output logic               hit_pulse,
  output logic [SCORE_W-1:0] score,
  output logic               cleared
`ifdef BREAKOUT_HP_SHADE_EN
  ,
  output logic [2:0]         pix_hp
`endif
);

  localparam int COL_X_R   = COL_X_L + BLOCK_W - 1;
  localparam int CNT_W     = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam int IDX_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  typedef enum logic {IDLE, COOLDOWN} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [2:0]         hp [NUM_ROWS];
  logic               found, take, all_dead;
  logic [IDX_W-1:0]   sel_idx;
  logic [3:0]         sel_dir;
  logic [SCORE_W-1:0] score_nx;

  // Pixel test: a dead block (hp == 0) is never drawn.
  always_comb begin
    int px, py, t;
    col_on = 1'b0;
`ifdef BREAKOUT_HP_SHADE_EN
    pix_hp = 3'd0;
`endif
    px = int'(pix_x);
    py = int'(pix_y);
    for (int r = 0; r < NUM_ROWS; r++) begin
      t = ROW_Y0 + r * ROW_PITCH;
      if (py >= t && py <= t + BLOCK_H - 1 && px >= COL_X_L && px <= COL_X_R && hp[r] != 3'd0) begin
        col_on = 1'b1;
`ifdef BREAKOUT_HP_SHADE_EN
        pix_hp = hp[r];
`endif
      end
    end
  end

  // Contact: lowest-index live row with any side contact wins; sel_dir is {u, d, l, r}.
  always_comb begin
    int xl, xr, yt, yb, t, b;
    logic yov, xov;
    logic [3:0] dir;
    found   = 1'b0;
    sel_idx = '0;
    sel_dir = 4'b0000;
    xl = int'(ball_x_l);
    xr = int'(ball_x_r);
    yt = int'(ball_y_t);
    yb = int'(ball_y_b);
    xov = (xr >= COL_X_L) && (xl <= COL_X_R);
    for (int r = 0; r < NUM_ROWS; r++) begin
      t   = ROW_Y0 + r * ROW_PITCH;
      b   = t + BLOCK_H - 1;
      yov = (yb >= t) && (yt <= b);
      dir[3] = (yb >= t) && (yb <= t + EDGE_T) && xov;
      dir[2] = (yt >= b - EDGE_T) && (yt <= b) && xov;
      dir[1] = (xr >= COL_X_L) && (xr <= COL_X_L + EDGE_T) && yov;
      dir[0] = (xl >= COL_X_R - EDGE_T) && (xl <= COL_X_R) && yov;
      if (!found && hp[r] != 3'd0 && dir != 4'b0000) begin
        found   = 1'b1;
        sel_idx = IDX_W'(r);
        sel_dir = dir;
      end
    end
  end

  always_comb begin
    int s;
    all_dead = 1'b1;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (hp[r] != 3'd0) all_dead = 1'b0;
    end
    s = int'(score) + PTS_PER_BLOCK;
    score_nx = (s > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(s);
  end

  // Cooldown with a zero count still spends one cycle in COOLDOWN before re-arming.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take     = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick && found) begin
          take     = 1'b1;
          state_nx = COOLDOWN;
          cnt_nx   = CNT_W'(COOLDOWN_FRAMES);
        end
      end
      COOLDOWN: begin
        if (cnt == '0) begin
          state_nx = IDLE;
        end else if (frame_tick) begin
          cnt_nx = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      for (int r = 0; r < NUM_ROWS; r++) hp[r] <= 3'(HIT_POINTS);
      score     <= '0;
      move_u    <= 1'b0;
      move_d    <= 1'b0;
      move_l    <= 1'b0;
      move_r    <= 1'b0;
      hit_pulse <= 1'b0;
      cleared   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      {move_u, move_d, move_l, move_r} <= take ? sel_dir : 4'b0000;
      hit_pulse <= take;
      if (take) begin
        hp[sel_idx] <= hp[sel_idx] - 3'd1;
        if (hp[sel_idx] == 3'd1) score <= score_nx;
      end
      if (all_dead) cleared <= 1'b1;
    end
  end

endmodule

// File: tb/tb_breakout_block_column.sv
// Bench for breakout_block_column: three instances (default, HIT_POINTS=3, SCORE_W=3/PTS=2)
// with independent ball inputs; pulses are checked by a scoreboard monitor against queued expectations.
module tb_breakout_block_column;
  localparam int W = 29;  // {cycle[15:0], hit_pulse, u, d, l, r, score[7:0]}
  localparam logic [10:0] PARK = 11'd2040;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [10:0] pix_x = '0, pix_y = '0;
  logic [10:0] bxl[3], bxr[3], byt[3], byb[3];
  logic        col_on[3], mu[3], md[3], ml[3], mr[3], hit_p[3], clr[3];
  logic [7:0]  sc0, sc1;
  logic [2:0]  sc2;
  logic [15:0] cyc = '0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  int checks = 0;
  int failures = 0;

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  breakout_block_column u0 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(bxl[0]), .ball_x_r(bxr[0]), .ball_y_t(byt[0]), .ball_y_b(byb[0]),
    .col_on(col_on[0]), .move_u(mu[0]), .move_d(md[0]), .move_l(ml[0]), .move_r(mr[0]),
    .hit_pulse(hit_p[0]), .score(sc0), .cleared(clr[0]));

  breakout_block_column #(.HIT_POINTS(3)) u1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(bxl[1]), .ball_x_r(bxr[1]), .ball_y_t(byt[1]), .ball_y_b(byb[1]),
    .col_on(col_on[1]), .move_u(mu[1]), .move_d(md[1]), .move_l(ml[1]), .move_r(mr[1]),
    .hit_pulse(hit_p[1]), .score(sc1), .cleared(clr[1]));

  breakout_block_column #(.SCORE_W(3), .PTS_PER_BLOCK(2)) u2 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(bxl[2]), .ball_x_r(bxr[2]), .ball_y_t(byt[2]), .ball_y_b(byb[2]),
    .col_on(col_on[2]), .move_u(mu[2]), .move_d(md[2]), .move_l(ml[2]), .move_r(mr[2]),
    .hit_pulse(hit_p[2]), .score(sc2), .cleared(clr[2]));

  function automatic logic [7:0] score_of(input int i);
    case (i)
      0: return sc0;
      1: return sc1;
      default: return {5'b00000, sc2};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitor: any pulse or move bit must match the head of that instance's queue
  always @(negedge clk) begin
    logic [W-1:0] act, exp;
    logic have;
    for (int i = 0; i < 3; i++) begin
      if (hit_p[i] | mu[i] | md[i] | ml[i] | mr[i]) begin
        act  = {cyc, hit_p[i], mu[i], md[i], ml[i], mr[i], score_of(i)};
        exp  = '0;
        have = 1'b0;
        case (i)
          0: if (exp_q0.size() > 0) begin exp = exp_q0.pop_front(); have = 1'b1; end
          1: if (exp_q1.size() > 0) begin exp = exp_q1.pop_front(); have = 1'b1; end
          default: if (exp_q2.size() > 0) begin exp = exp_q2.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
          failures++;
          $display("FAIL unexpected_pulse u%0d: got %h expected none", i, act);
        end else if (act !== exp) begin
          failures++;
          $display("FAIL pulse u%0d: got %h expected %h", i, act, exp);
        end
      end
    end
  end

  // driver tasks
  task automatic set_ball(input int i, input int xl, input int xr, input int yt, input int yb);
    bxl[i] = 11'(xl); bxr[i] = 11'(xr); byt[i] = 11'(yt); byb[i] = 11'(yb);
  endtask

  task automatic park(input int i);
    bxl[i] = PARK; bxr[i] = PARK; byt[i] = PARK; byb[i] = PARK;
  endtask

  task automatic tick(input int inst, input logic [3:0] dir, input logic [7:0] sc, input bit expect_hit);
    logic [W-1:0] e;
    @(negedge clk);
    frame_tick = 1'b1;
    if (expect_hit) begin
      e = {cyc + 16'd1, 1'b1, dir, sc};
      case (inst)
        0: exp_q0.push_back(e);
        1: exp_q1.push_back(e);
        default: exp_q2.push_back(e);
      endcase
    end
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("queue_drained", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
  endtask

  task automatic hit(input int i, input int xl, input int xr, input int yt, input int yb,
                     input logic [3:0] dir, input logic [7:0] sc);
    set_ball(i, xl, xr, yt, yb);
    tick(i, dir, sc, 1'b1);
    park(i);
    tick(i, 4'b0000, 8'd0, 1'b0);
    tick(i, 4'b0000, 8'd0, 1'b0);
  endtask

  task automatic probe(input int i, input int x, input int y, input logic exp);
    pix_x = 11'(x);
    pix_y = 11'(y);
    #1 check($sformatf("col_on u%0d (%0d,%0d)", i, x, y), col_on[i], exp);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  int px_t[6] = '{574, 679, 600, 600, 573, 680};
  int py_t[6] = '{4, 19, 165, 20, 10, 10};
  logic on_t[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    for (int i = 0; i < 3; i++) park(i);
    apply_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_score u%0d", i), score_of(i), 0);
      check($sformatf("rst_cleared u%0d", i), clr[i], 0);
      check($sformatf("rst_pulses u%0d", i), {hit_p[i], mu[i], md[i], ml[i], mr[i]}, 0);
    end

    // static raster
    for (int k = 0; k < 6; k++) probe(0, px_t[k], py_t[k], on_t[k]);

    // right-edge hit on row 0
    hit(0, 676, 683, 8, 15, 4'b0001, 8'd1);
    probe(0, 600, 10, 1'b0);
    check("score_after_row0", sc0, 1);

    // ball touching row 1 bottom band and row 2 top band: row 1 wins
    hit(0, 600, 607, 41, 50, 4'b0100, 8'd2);
    probe(0, 600, 30, 1'b0);
    probe(0, 600, 50, 1'b1);

    // multi-hit block with cooldown: hits on ticks 1, 4, 7
    set_ball(1, 570, 575, 8, 15);
    for (int k = 1; k <= 12; k++)
      tick(1, 4'b0010, (k == 7) ? 8'd1 : 8'd0, (k == 1) || (k == 4) || (k == 7));
    park(1);
    check("u1_score_after_12", sc1, 1);
    probe(1, 600, 10, 1'b0);

    // destroy remaining rows 2..7 from below-top band
    for (int r = 2; r < 8; r++) begin
      if (r == 7) check("cleared_before_last", clr[0], 0);
      hit(0, 600, 607, 4 + 23 * r - 5, 4 + 23 * r + 1, 4'b1000, 8'(r + 1));
    end
    check("score_all_rows", sc0, 8);
    check("cleared_all_rows", clr[0], 1);
    probe(0, 600, 165, 1'b0);

    // saturation: 3-bit score, 2 points per block
    for (int r = 0; r < 4; r++)
      hit(2, 600, 607, 4 + 23 * r - 5, 4 + 23 * r + 1, 4'b1000, (r == 3) ? 8'd7 : 8'(2 * (r + 1)));
    check("u2_score_saturated", sc2, 7);

    // reset during cooldown coinciding with a tick and contact
    apply_reset();
    set_ball(0, 676, 683, 8, 15);
    tick(0, 4'b0001, 8'd1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("post_reset_score", sc0, 0);
    check("post_reset_cleared", clr[0], 0);
    probe(0, 600, 10, 1'b1);
    tick(0, 4'b0001, 8'd1, 1'b1);
    park(0);
    check("final_score", sc0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
